// File: rtl/seq_shifter.sv
// Multi-cycle shifter: SLL/SRL/SRA/ROR, one bit position per clock, start/done handshake.
// Optional zero/carry flag ports are built when SEQ_SHIFTER_FLAGS_EN is defined.
module seq_shifter #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CW    = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Z
`ifdef SEQ_SHIFTER_FLAGS_EN
  ,
  output logic             zero,
  output logic             carry
`endif
);

  localparam int unsigned LW = $clog2(WIDTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam logic [1:0] OP_SLL = 2'd0;
  localparam logic [1:0] OP_SRL = 2'd1;
  localparam logic [1:0] OP_SRA = 2'd2;
  localparam logic [1:0] OP_ROR = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CW-1:0]    load_cnt;
  logic [1:0]       op_q, op_d;
`ifdef SEQ_SHIFTER_FLAGS_EN
  logic             carry_q, carry_d;
  logic             zero_q;
`endif

  // Status decodes straight from the state register; no path from start.
  assign ready = (state_q == S_IDLE) || (state_q == S_DONE);
  assign busy  = (state_q == S_SHIFT);
  assign done  = (state_q == S_DONE);
  assign Z     = work_q;
`ifdef SEQ_SHIFTER_FLAGS_EN
  assign zero  = zero_q;
  assign carry = carry_q;
`endif

  // Shift count at accept: saturate linear shifts, wrap rotates.
  always_comb begin
    load_cnt = '0;
    if (op == OP_ROR)
      load_cnt = CW'(B[LW-1:0]);
    else if (B >= WIDTH'(WIDTH))
      load_cnt = CW'(WIDTH);
    else
      load_cnt = B[CW-1:0];
  end

  // State register and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      work_q  <= '0;
      cnt_q   <= '0;
      op_q    <= OP_SLL;
`ifdef SEQ_SHIFTER_FLAGS_EN
      carry_q <= 1'b0;
      zero_q  <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
`ifdef SEQ_SHIFTER_FLAGS_EN
      carry_q <= carry_d;
      zero_q  <= (work_d == '0);
`endif
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
`ifdef SEQ_SHIFTER_FLAGS_EN
    carry_d = carry_q;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (start) begin
          work_d  = A;
          op_d    = op;
          cnt_d   = load_cnt;
          state_d = (load_cnt == '0) ? S_DONE : S_SHIFT;
`ifdef SEQ_SHIFTER_FLAGS_EN
          carry_d = 1'b0;
`endif
        end
      end
      S_SHIFT: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1))
          state_d = S_DONE;
        case (op_q)
          OP_SLL: work_d = {work_q[WIDTH-2:0], 1'b0};
          OP_SRL: work_d = {1'b0, work_q[WIDTH-1:1]};
          OP_SRA: work_d = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
          default: work_d = {work_q[0], work_q[WIDTH-1:1]};
        endcase
`ifdef SEQ_SHIFTER_FLAGS_EN
        // Bit leaving the register; for ROR it is also the new MSB.
        carry_d = (op_q == OP_SLL) ? work_q[WIDTH-1] : work_q[0];
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule
